mix_shift_seq: RTL

- Sequential executor for MIX shift operators, command 6, fields 0–5: SLA, SRA, SLAX, SRAX, SLC, SRC.
- Shifts rA, or rA:rX as one 10-byte register, by M bytes, one byte per clock.
- Register-side counterpart to the address-transfer path: consumes an address-derived count and rewrites registers. Sits beside the ALU and is driven by the control sequencer through a start/done handshake.

---
 rtl/mix_pkg.sv | 35 +++
 rtl/mix_shift_step.sv | 30 +++
 rtl/mix_shift_seq.sv | 98 +++++++++
 3 files changed

// File: rtl/mix_pkg.sv
// Shared definitions for the MIX shift executor: field codes, word geometry,
// sequencer states and the effective-count helper.
package mix_pkg;

    localparam int BYTE_W = 6;
    localparam int NBYTES = 5;
    localparam int MAG_W  = NBYTES * BYTE_W;
    localparam int WORD_W = MAG_W + 1;
    localparam int CNT_W  = 4;

    localparam logic [2:0] F_SLA  = 3'd0;
    localparam logic [2:0] F_SRA  = 3'd1;
    localparam logic [2:0] F_SLAX = 3'd2;
    localparam logic [2:0] F_SRAX = 3'd3;
    localparam logic [2:0] F_SLC  = 3'd4;
    localparam logic [2:0] F_SRC  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_e;

    // Single-register shifts saturate at one word, double shifts at two words,
    // rotates only need the residue modulo the ten-byte ring.
    function automatic logic [CNT_W-1:0] eff_count(input logic [2:0] f, input logic [11:0] k);
        case (f)
            F_SLA, F_SRA:   eff_count = (k > 12'd5)  ? 4'd5  : k[3:0];
            F_SLAX, F_SRAX: eff_count = (k > 12'd10) ? 4'd10 : k[3:0];
            F_SLC, F_SRC:   eff_count = 4'(k % 12'd10);
            default:        eff_count = '0;
        endcase
    endfunction

endpackage

// File: rtl/mix_shift_step.sv
// Combinational one-byte shift/rotate of the rA / rA:rX magnitudes.
// Signs are handled by the caller; unknown field codes pass data through.
module mix_shift_step
    import mix_pkg::*;
(
    input  logic [2:0]       field,
    input  logic [MAG_W-1:0] a_mag,
    input  logic [MAG_W-1:0] x_mag,
    output logic [MAG_W-1:0] a_nxt,
    output logic [MAG_W-1:0] x_nxt
);

    logic [2*MAG_W-1:0] ax;

    always_comb begin
        ax    = {a_mag, x_mag};
        a_nxt = a_mag;
        x_nxt = x_mag;
        case (field)
            F_SLA:  a_nxt = a_mag << BYTE_W;
            F_SRA:  a_nxt = a_mag >> BYTE_W;
            F_SLAX: {a_nxt, x_nxt} = ax << BYTE_W;
            F_SRAX: {a_nxt, x_nxt} = ax >> BYTE_W;
            F_SLC:  {a_nxt, x_nxt} = {ax[2*MAG_W-BYTE_W-1:0], ax[2*MAG_W-1 -: BYTE_W]};
            F_SRC:  {a_nxt, x_nxt} = {ax[BYTE_W-1:0], ax[2*MAG_W-1:BYTE_W]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mix_shift_seq.sv
// Sequential MIX shift executor (SLA/SRA/SLAX/SRAX/SLC/SRC), one byte per clock.
// a_out/x_out double as the working registers and hold the result after done.
module mix_shift_seq
    import mix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        field,
    input  logic [12:0]       m,
    input  logic [WORD_W-1:0] a_in,
    input  logic [WORD_W-1:0] x_in,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [WORD_W-1:0] a_out,
    output logic [WORD_W-1:0] x_out
);

    // Handshake: start is taken only in IDLE; busy rises the cycle after acceptance
    // and stays high through the single-cycle done pulse, when results are valid.
    state_e            state_q, state_d;
    logic [WORD_W-1:0] a_q, a_d, x_q, x_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        field_q, field_d;
    logic              busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
    logic              legal;
    logic [MAG_W-1:0]  a_step, x_step;

    mix_shift_step u_step (
        .field (field_q),
        .a_mag (a_q[MAG_W-1:0]),
        .x_mag (x_q[MAG_W-1:0]),
        .a_nxt (a_step),
        .x_nxt (x_step)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        x_d       = x_q;
        cnt_d     = cnt_q;
        field_d   = field_q;
        illegal_d = 1'b0;
        legal     = (field <= F_SRC) && !m[12];
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d       = a_in;
                    x_d       = x_in;
                    field_d   = field;
                    cnt_d     = legal ? eff_count(field, m[11:0]) : '0;
                    illegal_d = !legal;
                    state_d   = (cnt_d != '0) ? ST_SHIFT : ST_FIN;
                end
            end
            ST_SHIFT: begin
                a_d   = {a_q[WORD_W-1], a_step};
                x_d   = {x_q[WORD_W-1], x_step};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 4'd1) state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            x_q       <= '0;
            cnt_q     <= '0;
            field_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            field_q   <= field_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign a_out   = a_q;
    assign x_out   = x_q;

endmodule
